// File: rtl/crc8_pkg.sv
// -----------------------------------------------------------------------------
// crc8_pkg
// Shared definitions for the serial CRC-8 engine.
//   CRC_W        : width of the CRC register (8)
//   LEN_W        : width of the frame length counter (16)
//   DEFAULT_POLY : default generator polynomial, x^8 term implicit (8'h07)
//   LEN_MAX      : saturation value of the length counter
//   state_t      : frame-level FSM states IDLE / SHIFT / HOLD
// -----------------------------------------------------------------------------
package crc8_pkg;

    localparam int CRC_W = 8;
    localparam int LEN_W = 16;

    localparam logic [CRC_W-1:0] DEFAULT_POLY = 8'h07;
    localparam logic [LEN_W-1:0] LEN_MAX      = '1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

endpackage

// File: rtl/crc8_step.sv
// -----------------------------------------------------------------------------
// crc8_step
// Combinational one-bit CRC-8 update, MSB-first (non-reflected) form.
// Ports:
//   crc_in  [CRC_W-1:0] in  : current CRC register value
//   in_bit              in  : serial data bit being absorbed
//   crc_out [CRC_W-1:0] out : CRC register value after absorbing in_bit
// Parameter:
//   POLY : generator polynomial without the implicit x^8 term
// -----------------------------------------------------------------------------
module crc8_step
    import crc8_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = DEFAULT_POLY
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic             in_bit,
    output logic [CRC_W-1:0] crc_out
);

    logic fb;

    // The feedback bit decides whether the polynomial is folded back in
    // after the register shifts left by one place.
    assign fb      = crc_in[CRC_W-1] ^ in_bit;
    assign crc_out = {crc_in[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc8_serial.sv
// -----------------------------------------------------------------------------
// crc8_serial
// Bit-serial CRC-8 engine with a valid/ready input stream and a valid/ready
// result. Bits arrive MSB-first; in_last marks the final bit of a frame.
// Once the frame closes, the CRC, bit count (saturating at 16'hFFFF) and
// optional parity are held until the consumer takes them with out_ready.
//
// Ports:
//   clk        in   : clock, all state updates on the rising edge
//   rst        in   : synchronous active-high reset
//   in_bit     in   : serial data bit
//   in_valid   in   : in_bit is valid this cycle
//   in_last    in   : current bit closes the frame (qualified by in_valid)
//   in_ready   out  : a bit can be accepted this cycle
//   out_crc    out  : CRC of the completed frame (zero when out_valid=0)
//   out_len    out  : bit count of the completed frame (zero when out_valid=0)
//   out_valid  out  : out_crc / out_len (/ out_parity) are valid
//   out_parity out  : XOR of all accepted bits, only with CRC8_SERIAL_PARITY_EN
//   out_ready  in   : consumer accepts the result this cycle
//
// Parameters:
//   POLY : generator polynomial without the x^8 term (default 8'h07)
//   INIT : CRC register value at the start of each frame (default 8'h00)
//
// Build option:
//   CRC8_SERIAL_PARITY_EN : when defined, adds the out_parity port and its
//                           register; otherwise neither exists.
// -----------------------------------------------------------------------------
module crc8_serial
    import crc8_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = DEFAULT_POLY,
    parameter logic [CRC_W-1:0] INIT = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [CRC_W-1:0] out_crc,
    output logic [LEN_W-1:0] out_len,
    output logic             out_valid,
`ifdef CRC8_SERIAL_PARITY_EN
    output logic             out_parity,
`endif
    input  logic             out_ready
);

    state_t             state_q, state_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CRC_W-1:0]   crc_step;
    logic               accept;
`ifdef CRC8_SERIAL_PARITY_EN
    logic               parity_q, parity_d;
`endif

    crc8_step #(
        .POLY    (POLY)
    ) u_step (
        .crc_in  (crc_q),
        .in_bit  (in_bit),
        .crc_out (crc_step)
    );

    // in_ready is forced low during reset so nothing is taken in a cycle whose
    // effect the reset is about to discard; out_valid is gated the same way so
    // a pending result is never offered while it is being thrown away.
    assign in_ready  = ~rst && (state_q != HOLD);
    assign out_valid = ~rst && (state_q == HOLD);
    assign accept    = in_valid && in_ready;

    // Results read as zero outside HOLD, which also gives the zero values the
    // outputs must show while reset is applied.
    assign out_crc = out_valid ? crc_q : '0;
    assign out_len = out_valid ? len_q : '0;
`ifdef CRC8_SERIAL_PARITY_EN
    assign out_parity = out_valid ? parity_q : 1'b0;
`endif

    // Next-state logic. IDLE and SHIFT share the update path because crc_q is
    // already INIT and len_q already zero whenever the FSM sits in IDLE.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        len_d   = len_q;
`ifdef CRC8_SERIAL_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE, SHIFT: begin
                if (accept) begin
                    crc_d   = crc_step;
                    len_d   = (len_q == LEN_MAX) ? len_q : len_q + 16'd1;
                    state_d = in_last ? HOLD : SHIFT;
`ifdef CRC8_SERIAL_PARITY_EN
                    parity_d = parity_q ^ in_bit;
`endif
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    crc_d   = INIT;
                    len_d   = '0;
`ifdef CRC8_SERIAL_PARITY_EN
                    parity_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                crc_d   = INIT;
                len_d   = '0;
`ifdef CRC8_SERIAL_PARITY_EN
                parity_d = 1'b0;
`endif
            end
        endcase
    end

    // State registers with synchronous reset back to the start-of-frame values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            crc_q   <= INIT;
            len_q   <= '0;
`ifdef CRC8_SERIAL_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            len_q   <= len_d;
`ifdef CRC8_SERIAL_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_crc8_serial.sv
// -----------------------------------------------------------------------------
// tb_crc8_serial
// Self-checking bench for crc8_serial (POLY=8'h07, INIT=8'h00). Expected CRCs
// come from polynomial long division of the frame augmented with eight zero
// bits; lengths and parity come from counting bits in the frame.
// -----------------------------------------------------------------------------
module tb_crc8_serial;

    typedef bit bitq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        in_bit;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  out_crc;
    logic [15:0] out_len;
    logic        out_valid;
    logic        out_ready;
`ifdef CRC8_SERIAL_PARITY_EN
    logic        out_parity;
`endif

    int checks = 0;
    int errors = 0;

    crc8_serial #(
        .POLY       (8'h07),
        .INIT       (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_crc    (out_crc),
        .out_len    (out_len),
        .out_valid  (out_valid),
`ifdef CRC8_SERIAL_PARITY_EN
        .out_parity (out_parity),
`endif
        .out_ready  (out_ready)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Remainder of M(x)*x^8 divided by x^8 + x^2 + x + 1, done as schoolbook
    // long division over a bit array.
    function automatic logic [7:0] ref_crc(input bitq_t msg);
        bitq_t      work;
        logic [8:0] gen;
        logic [7:0] r;
        gen  = 9'h107;
        work = msg;
        for (int k = 0; k < 8; k++) work.push_back(1'b0);
        for (int i = 0; i < msg.size(); i++) begin
            if (work[i]) begin
                for (int j = 0; j < 9; j++) work[i + j] = work[i + j] ^ gen[8 - j];
            end
        end
        for (int k = 0; k < 8; k++) r[7 - k] = work[msg.size() + k];
        return r;
    endfunction

    function automatic logic [15:0] ref_len(input bitq_t msg);
        return (msg.size() > 65535) ? 16'hFFFF : 16'(msg.size());
    endfunction

    function automatic logic ref_parity(input bitq_t msg);
        int ones;
        ones = 0;
        foreach (msg[i]) ones += int'(msg[i]);
        return 1'(ones % 2);
    endfunction

    function automatic bitq_t byte_bits(input logic [7:0] b);
        bitq_t q;
        for (int i = 7; i >= 0; i--) q.push_back(b[i]);
        return q;
    endfunction

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive a bit sequence, optionally with random idle gaps before each bit.
    // On return the last bit has just been accepted.
    task automatic applyStimulus(input bitq_t bits, input bit with_last, input int max_gap);
        for (int i = 0; i < bits.size(); i++) begin
            int gap;
            int t;
            gap      = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            in_valid = 1'b0;
            repeat (gap) tick();
            in_bit   = bits[i];
            in_last  = with_last && (i == bits.size() - 1);
            in_valid = 1'b1;
            t = 0;
            while (in_ready !== 1'b1 && t < 20) begin
                tick();
                t++;
            end
            if (t == 20) checkOutput("ready_timeout", {31'b0, in_ready}, 32'd1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic checkFrame(input string tag, input logic [7:0] crc,
                              input logic [15:0] len, input logic par);
        checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        checkOutput({tag, "_crc"},   {24'b0, out_crc},   {24'b0, crc});
        checkOutput({tag, "_len"},   {16'b0, out_len},   {16'b0, len});
        checkOutput({tag, "_ready"}, {31'b0, in_ready},  32'd0);
`ifdef CRC8_SERIAL_PARITY_EN
        checkOutput({tag, "_parity"}, {31'b0, out_parity}, {31'b0, par});
`endif
    endtask

    task automatic releaseResult(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, "_rel_valid"}, {31'b0, out_valid}, 32'd0);
        checkOutput({tag, "_rel_ready"}, {31'b0, in_ready},  32'd1);
    endtask

    initial begin
        bitq_t frame;

        rst       = 1'b1;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();

        // Reset values.
        checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_crc",   {24'b0, out_crc},   32'd0);
        checkOutput("rst_len",   {16'b0, out_len},   32'd0);
        checkOutput("rst_ready", {31'b0, in_ready},  32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_ready", {31'b0, in_ready}, 32'd1);

        // Single-bit frame.
        $display("[TB] single-bit frame");
        frame = {};
        frame.push_back(1'b1);
        applyStimulus(frame, 1'b1, 0);
        checkFrame("single", 8'h07, 16'd1, 1'b1);
        releaseResult("single");

        // Byte 8'h01.
        $display("[TB] byte 01");
        applyStimulus(byte_bits(8'h01), 1'b1, 0);
        checkFrame("b01", 8'h07, 16'd8, 1'b1);
        releaseResult("b01");

        // Byte 8'hFF back-to-back, then with idle gaps.
        $display("[TB] byte FF with and without gaps");
        applyStimulus(byte_bits(8'hFF), 1'b1, 0);
        checkFrame("bff", 8'hF3, 16'd8, 1'b0);
        releaseResult("bff");
        applyStimulus(byte_bits(8'hFF), 1'b1, 3);
        checkFrame("bff_gap", 8'hF3, 16'd8, 1'b0);
        releaseResult("bff_gap");

        // Consumer stalls for 5 cycles while upstream presents a bit.
        $display("[TB] hold with out_ready low");
        applyStimulus(byte_bits(8'hFF), 1'b1, 0);
        in_bit   = 1'b1;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checkFrame($sformatf("hold%0d", c), 8'hF3, 16'd8, 1'b0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        releaseResult("hold");
        applyStimulus(byte_bits(8'h01), 1'b1, 0);
        checkFrame("after_hold", 8'h07, 16'd8, 1'b1);
        releaseResult("after_hold");

        // Reset after 4 bits of a frame.
        $display("[TB] reset mid-frame");
        frame = byte_bits(8'hA5);
        frame = frame[0:3];
        applyStimulus(frame, 1'b0, 0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_ready", {31'b0, in_ready}, 32'd0);
        tick();
        checkOutput("midrst_valid", {31'b0, out_valid}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("midrst_post_ready", {31'b0, in_ready}, 32'd1);
        repeat (3) tick();
        checkOutput("midrst_no_output", {31'b0, out_valid}, 32'd0);
        applyStimulus(byte_bits(8'hFF), 1'b1, 0);
        checkFrame("midrst_next", 8'hF3, 16'd8, 1'b0);
        releaseResult("midrst_next");

        // Reset while a result is pending.
        $display("[TB] reset in hold");
        applyStimulus(byte_bits(8'h01), 1'b1, 0);
        rst = 1'b1;
        #1;
        checkOutput("holdrst_valid_now", {31'b0, out_valid}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("holdrst_valid_after", {31'b0, out_valid}, 32'd0);
        checkOutput("holdrst_ready", {31'b0, in_ready}, 32'd1);

        // Random frames against the reference model.
        $display("[TB] random frames");
        for (int f = 0; f < 12; f++) begin
            int n;
            frame = {};
            n = int'($urandom_range(24, 1));
            for (int i = 0; i < n; i++) frame.push_back(1'($urandom_range(1, 0)));
            applyStimulus(frame, 1'b1, int'($urandom_range(2, 0)));
            checkFrame($sformatf("rand%0d", f), ref_crc(frame), ref_len(frame), ref_parity(frame));
            repeat ($urandom_range(2, 0)) tick();
            checkOutput($sformatf("rand%0d_still_valid", f), {31'b0, out_valid}, 32'd1);
            releaseResult($sformatf("rand%0d", f));
        end

        // Long all-zero frame to drive the length counter into saturation.
        $display("[TB] 70000-bit zero frame");
        in_bit   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            in_last = (i == 69999);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkFrame("long", 8'h00, 16'hFFFF, 1'b0);
        releaseResult("long");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc8_serial.md
CRC8_SERIAL -- requirements
Module: crc8_serial

Interface
REQ-001 The block SHALL have parameter POLY, default 8'h07, meaning the CRC-8 generator polynomial without the implicit x^8 term.
REQ-002 The block SHALL have parameter INIT, default 8'h00, meaning the CRC register value at the start of each frame.
REQ-003 Port clk  input  1  meaning the single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  meaning reset, synchronous and active-high.
REQ-005 Port in_bit  input  1  meaning serial data bit, MSB-first.
REQ-006 Port in_valid  input  1  meaning in_bit is valid this cycle.
REQ-007 Port in_last  input  1  meaning the current bit is the final bit of the frame; qualified by in_valid.
REQ-008 Port in_ready  output  1  meaning the block can accept a bit this cycle.
REQ-009 Port out_crc  output  8  meaning the final CRC of the completed frame.
REQ-010 Port out_len  output  16  meaning the number of bits in the completed frame.
REQ-011 Port out_valid  output  1  meaning out_crc and out_len are valid.
REQ-012 Port out_ready  input  1  meaning the consumer accepts the result this cycle.

Function
REQ-013 A bit SHALL be accepted only when in_valid && in_ready in the same cycle.
REQ-014 On each accepted bit: fb = crc[7] XOR in_bit; crc_next = {crc[6:0],0} XOR (fb ? POLY : 0).
REQ-015 States SHALL be IDLE, SHIFT and HOLD.
REQ-016 IDLE: in_ready=1, crc=INIT, len=0; an accepted non-last bit -> SHIFT; an accepted last bit -> HOLD.
REQ-017 SHIFT: in_ready=1; each accepted bit updates crc and len; an accepted last bit -> HOLD.
REQ-018 HOLD: in_ready=0, out_valid=1, out_crc and out_len stable; out_ready=1 -> IDLE next cycle, crc reloaded with INIT.
REQ-019 Latency: out_valid SHALL rise on the first clock edge after the last bit is accepted.
REQ-020 The len counter SHALL count accepted bits including the last bit, and saturate at 16'hFFFF without wrapping.
REQ-021 Cycles with in_valid=0 SHALL leave crc, len and state unchanged.
REQ-022 In HOLD, in_valid SHALL be ignored and no bit consumed; upstream holds its data until in_ready returns.
REQ-023 out_crc and out_len SHALL be don't-care whenever out_valid=0; the bench does not check them then.

Reset
REQ-024 While rst=1 at a clock edge: state=IDLE, crc=INIT, len=0, out_valid=0, out_crc=0, out_len=0.
REQ-025 Reset mid-frame or in HOLD SHALL discard the partial or pending result with no output produced.
REQ-026 in_ready SHALL be 0 during the reset cycle and 1 on the first cycle after rst deasserts.

Configuration
REQ-027 Macro CRC8_SERIAL_PARITY_EN SHALL, when defined, add output port out_parity (1 bit): the XOR of all accepted bits of the frame, valid with out_valid, reset to 0.
REQ-028 Without CRC8_SERIAL_PARITY_EN, port out_parity and its register SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-029 Package crc8_pkg SHALL hold the state enum (IDLE, SHIFT, HOLD), CRC_W=8, LEN_W=16 and the default polynomial constant 8'h07.
REQ-030 Sub-module crc8_step SHALL compute the combinational one-bit update of REQ-014, using the existing 2-input XOR cell for feedback; crc8_serial instantiates it once.

Verification
REQ-031 Single-bit frame in_bit=1, in_last=1 -> out_crc=8'h07, out_len=1, out_parity=1.
REQ-032 Byte 8'h01 MSB-first, last on bit 8 -> out_crc=8'h07, out_len=8, out_parity=1.
REQ-033 Byte 8'hFF -> out_crc=8'hF3, out_len=8, out_parity=0; in_valid gaps inserted between bits -> identical result.
REQ-034 Hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, presented bits not consumed; out_ready=1 -> IDLE, next frame 8'h01 gives 8'h07.
REQ-035 rst=1 after 4 bits of a frame -> out_valid never asserted; new frame 8'hFF afterwards -> out_crc=8'hF3.
REQ-036 Frame of 70000 zero bits -> out_len=16'hFFFF, out_crc=8'h00.
